// File: rtl/accel_reg_bridge_pkg.sv
// Shared types and address constants for the accelerator register bridge.
// Address 13 is only decoded when ACCEL_BRIDGE_WRCOUNT_EN is defined.
package accel_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int ADDR_WR_COUNT   = 13;
    localparam int ADDR_IRQ_STATUS = 14;
    localparam int ADDR_IRQ_ENABLE = 15;

    localparam int WRCOUNT_W = 16;

    // Addresses below the register count are forwarded to the accelerator.
    function automatic logic is_fwd(input logic [31:0] addr, input int reg_count);
        return addr < 32'(reg_count);
    endfunction

endpackage

// File: rtl/accel_reg_bridge_irq_edge.sv
// Interrupt stage: rising-edge capture of the accelerator irq level,
// W1C pending bit (set wins over clear), enable bit, registered output.
module accel_irq_edge
    import accel_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic clr_i,
    input  logic en_we_i,
    input  logic en_d_i,
    output logic pending_o,
    output logic enable_o,
    output logic irq_o
);

    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic en_q;
    logic irq_q;
    logic rise;

    assign rise = irq_i & ~prev_q;

    always_comb begin
        pend_d = pend_q;
        if (rise) begin
            pend_d = 1'b1;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            en_q   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= irq_i;
            pend_q <= pend_d;
            if (en_we_i) begin
                en_q <= en_d_i;
            end
            // Output follows the registered pending/enable, one cycle behind.
            irq_q <= pend_q & en_q;
        end
    end

    assign pending_o = pend_q;
    assign enable_o  = en_q;
    assign irq_o     = irq_q;

endmodule

// File: rtl/accel_reg_bridge.sv
// Host valid/ready to single-cycle accelerator register port bridge.
// Define ACCEL_BRIDGE_WRCOUNT_EN to map a forwarded-write counter at address 13.
module accel_reg_bridge
    import accel_bridge_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              acc_wr_en,
    output logic [ADDR_W-1:0] acc_addr,
    output logic [DATA_W-1:0] acc_wr_data,
    input  logic [DATA_W-1:0] acc_rd_data,
    input  logic              acc_irq,
    output logic              irq_out
);

    state_e            state_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_en_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic [31:0]       addr_x;
    logic              in_access;
    logic              fwd;
    logic              is_stat;
    logic              is_en;
    logic [DATA_W-1:0] rd_val;
    logic              err;
    logic              irq_clr;
    logic              en_we;
    logic              irq_pending;
    logic              irq_enable;

`ifdef ACCEL_BRIDGE_WRCOUNT_EN
    logic                 is_cnt;
    logic [WRCOUNT_W-1:0] wr_count_q;
`endif

    assign addr_x    = 32'(addr_q);
    assign in_access = (state_q == ACCESS);
    assign fwd       = is_fwd(addr_x, REG_COUNT);
    assign is_stat   = (addr_x == 32'(ADDR_IRQ_STATUS));
    assign is_en     = (addr_x == 32'(ADDR_IRQ_ENABLE));
`ifdef ACCEL_BRIDGE_WRCOUNT_EN
    assign is_cnt    = (addr_x == 32'(ADDR_WR_COUNT));
`endif

    // Decode of the captured request; only consumed during ACCESS.
    always_comb begin
        rd_val = '0;
        err    = 1'b0;
        unique case (1'b1)
            fwd: begin
                if (!wr_q) rd_val = acc_rd_data;
            end
            is_stat: begin
                if (!wr_q) rd_val = DATA_W'(irq_pending);
            end
            is_en: begin
                if (!wr_q) rd_val = DATA_W'(irq_enable);
            end
`ifdef ACCEL_BRIDGE_WRCOUNT_EN
            is_cnt: begin
                if (!wr_q) rd_val = DATA_W'(wr_count_q);
            end
`endif
            default: begin
                err = 1'b1;
            end
        endcase
    end

    assign irq_clr = in_access & wr_q & is_stat & wdata_q[0];
    assign en_we   = in_access & wr_q & is_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wr_en_q     <= req_write &
                                       is_fwd(32'(req_addr), REG_COUNT);
                        req_ready_q <= 1'b0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    wr_en_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rd_val;
                    rsp_err_q   <= err;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ACCEL_BRIDGE_WRCOUNT_EN
    // Address 13 and forwarded addresses are disjoint, so clear and count never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
        end else if (in_access & wr_q & is_cnt) begin
            wr_count_q <= '0;
        end else if (in_access & wr_en_q) begin
            wr_count_q <= wr_count_q + 1'b1;
        end
    end
`endif

    accel_irq_edge u_irq (
        .clk       (clk),
        .rst       (rst),
        .irq_i     (acc_irq),
        .clr_i     (irq_clr),
        .en_we_i   (en_we),
        .en_d_i    (wdata_q[0]),
        .pending_o (irq_pending),
        .enable_o  (irq_enable),
        .irq_o     (irq_out)
    );

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign acc_wr_en   = wr_en_q;
    assign acc_addr    = addr_q;
    assign acc_wr_data = wdata_q;

endmodule

// File: tb/tb_accel_reg_bridge.sv
// Directed bench for accel_reg_bridge; address 13 checks follow
// ACCEL_BRIDGE_WRCOUNT_EN.
module tb_accel_reg_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        acc_wr_en;
    logic [3:0]  acc_addr;
    logic [31:0] acc_wr_data;
    logic [31:0] acc_rd_data;
    logic        acc_irq;
    logic        irq_out;

    int tests;
    int failed;

    accel_reg_bridge #(
        .ADDR_W    (4),
        .DATA_W    (32),
        .REG_COUNT (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .acc_wr_en   (acc_wr_en),
        .acc_addr    (acc_addr),
        .acc_wr_data (acc_wr_data),
        .acc_rd_data (acc_rd_data),
        .acc_irq     (acc_irq),
        .irq_out     (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accelerator register file model: addr 1 -> 0x1234, others addr ^ 0xA5A50000.
    always_comb begin
        acc_rd_data = {28'h0, acc_addr} ^ 32'hA5A5_0000;
        if (acc_addr == 4'd1) acc_rd_data = 32'h0000_1234;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction with rsp_ready high; called at a negedge while idle.
    task automatic xact(input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [31:0] er,
                        input logic ee, input logic ewr,
                        input logic raise, input string tag);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".wren"}, 32'(acc_wr_en), 32'(ewr));
        chk({tag, ".addr"}, 32'(acc_addr), 32'(a));
        chk({tag, ".wdat"}, acc_wr_data, d);
        chk({tag, ".rdy0"}, 32'(req_ready), 32'd0);
        chk({tag, ".vld0"}, 32'(rsp_valid), 32'd0);
        if (raise) acc_irq = 1'b1;
        @(negedge clk);
        chk({tag, ".vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, er);
        chk({tag, ".err"}, 32'(rsp_err), 32'(ee));
        chk({tag, ".wren0"}, 32'(acc_wr_en), 32'd0);
        @(negedge clk);
        chk({tag, ".vldoff"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rdy1"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int bad;
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        acc_irq   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst.rdy", 32'(req_ready), 32'd1);
        chk("rst.vld", 32'(rsp_valid), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        chk("rst.wren", 32'(acc_wr_en), 32'd0);
        chk("rst.addr", 32'(acc_addr), 32'd0);
        chk("rst.irq", 32'(irq_out), 32'd0);

        xact(1'b1, 4'd2, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0, "wr2");
        xact(1'b0, 4'd4, 32'h0, 32'hA5A5_0004, 1'b0, 1'b0, 1'b0, "rd4");
        xact(1'b0, 4'd9, 32'h0, 32'hA5A5_0009, 1'b0, 1'b0, 1'b0, "rd9");

        // Read addr 1 with a stalled response channel.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd1;
        req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("stall.vld", 32'(rsp_valid), 32'd1);
            chk("stall.rdata", rsp_rdata, 32'h1234);
            chk("stall.rdy", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall.vldoff", 32'(rsp_valid), 32'd0);
        chk("stall.rdy1", 32'(req_ready), 32'd1);

        xact(1'b0, 4'd11, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "rd11");
        xact(1'b1, 4'd12, 32'hDEAD, 32'h0, 1'b1, 1'b0, 1'b0, "wr12");

        // Interrupt path.
        xact(1'b1, 4'd15, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, "en1");
        xact(1'b0, 4'd15, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, "rden");
        xact(1'b0, 4'd14, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "st0");
        acc_irq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("irq.on", 32'(irq_out), 32'd1);
        xact(1'b0, 4'd14, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, "st1");
        xact(1'b1, 4'd14, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, "w1c");
        chk("irq.off", 32'(irq_out), 32'd0);
        xact(1'b0, 4'd14, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "stlvl");
        chk("irq.lvl", 32'(irq_out), 32'd0);
        acc_irq = 1'b0;
        @(negedge clk);
        acc_irq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("irq.re", 32'(irq_out), 32'd1);
        xact(1'b0, 4'd14, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, "stre");
        acc_irq = 1'b0;
        @(negedge clk);
        xact(1'b1, 4'd14, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, "w1crace");
        xact(1'b0, 4'd14, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, "strace");
        xact(1'b1, 4'd15, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0, "en0");
        chk("irq.mask", 32'(irq_out), 32'd0);
        xact(1'b0, 4'd15, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "rden0");

        // Reset during the ACCESS cycle of a write.
        acc_irq = 1'b0;
        xact(1'b1, 4'd15, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, "en1b");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd3;
        req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid.rdy", 32'(req_ready), 32'd1);
        chk("mid.vld", 32'(rsp_valid), 32'd0);
        chk("mid.wren", 32'(acc_wr_en), 32'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || acc_wr_en) bad++;
        end
        chk("mid.quiet", 32'(bad), 32'd0);
        xact(1'b0, 4'd15, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "mid.en");

`ifdef ACCEL_BRIDGE_WRCOUNT_EN
        xact(1'b0, 4'd13, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "cnt0");
        xact(1'b1, 4'd0, 32'h11, 32'h0, 1'b0, 1'b1, 1'b0, "cw0");
        xact(1'b1, 4'd1, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0, "cw1");
        xact(1'b1, 4'd2, 32'h33, 32'h0, 1'b0, 1'b1, 1'b0, "cw2");
        xact(1'b0, 4'd13, 32'h0, 32'h3, 1'b0, 1'b0, 1'b0, "cnt3");
        xact(1'b1, 4'd13, 32'hABCD, 32'h0, 1'b0, 1'b0, 1'b0, "cclr");
        xact(1'b0, 4'd13, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "cntc");
        dut.wr_count_q = 16'hFFFF;
        xact(1'b0, 4'd13, 32'h0, 32'hFFFF, 1'b0, 1'b0, 1'b0, "cntff");
        xact(1'b1, 4'd5, 32'h55, 32'h0, 1'b0, 1'b1, 1'b0, "cwrap");
        xact(1'b0, 4'd13, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "cntw");
`else
        xact(1'b0, 4'd13, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "rd13");
        xact(1'b1, 4'd13, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, "wr13");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
